// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master: FSM state encoding and
// SPI mode constants packed as {cpol, cpha}.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_CS_HELD,
    ST_GAP
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period timer: one-cycle tick every div_i+1 clocks while enabled.
// The counter is held at zero while disabled, so it restarts on every enable rise.
module spi_clk_tick
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = '0;
    if (en_i && !tick_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Runtime-configurable SPI master: CPOL/CPHA, bit order, clock divider and
// multi-word transfers under one chip select, driven by a valid/ready command stream.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CS_W-1:0]   cmd_cs,
  input  logic              cmd_last,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] idx);
    logic [NUM_CS-1:0] dec;
    dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (idx == CS_W'(i)) dec[i] = 1'b0;
    end
    return dec;
  endfunction

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  spi_state_e        state_q, state_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic [CS_W-1:0]   cs_idx_q, cs_idx_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              last_q, last_d;
  logic              pend_q, pend_d;

  logic accept, latch, start, tick, tick_en, leading, do_sample, do_shift;

  assign cmd_ready = rstn && (((state_q == ST_IDLE) && !pend_q) || (state_q == ST_CS_HELD));
  assign accept    = cmd_valid && cmd_ready;
  assign tick_en   = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                     (state_q == ST_HOLD)  || (state_q == ST_GAP);

  spi_clk_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rstn  (rstn),
    .en_i  (tick_en),
    .div_i (div_q),
    .tick_o(tick)
  );

  // Even edge index = leading SCK edge of a bit, odd = trailing.
  assign leading   = ~edge_q[0];
  assign do_sample = leading ^ cpha_q;
  assign do_shift  = cpha_q ? leading : (!leading && (edge_q != LAST_EDGE));

  always_comb begin
    state_d     = state_q;
    cs_n_d      = cs_n_q;
    cs_idx_d    = cs_idx_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    edge_d      = edge_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    div_d       = div_q;
    last_d      = last_q;
    pend_d      = pend_q;
    latch       = 1'b0;
    start       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          start  = 1'b1;
          pend_d = 1'b0;
        end else if (accept) begin
          latch = 1'b1;
          start = 1'b1;
        end
      end
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (tick) begin
          sck_d = ~sck_q;
          if (do_sample) begin
            rx_d = lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
          end
          if (do_shift) begin
            mosi_d = first_bit(tx_q, lsb_q);
            tx_d   = shift_out(tx_q, lsb_q);
          end
          if (edge_q == LAST_EDGE) state_d = ST_HOLD;
          else                     edge_d  = edge_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
          if (last_q) begin
            state_d = ST_GAP;
            cs_n_d  = '1;
          end else begin
            state_d = ST_CS_HELD;
          end
        end
      end
      ST_CS_HELD: begin
        if (accept) begin
          latch = 1'b1;
          // A changed target or idle level needs CS released before the next word.
          if ((cmd_cs == cs_idx_q) && (cfg_cpol == cpol_q)) begin
            start = 1'b1;
          end else begin
            pend_d  = 1'b1;
            state_d = ST_GAP;
            cs_n_d  = '1;
            sck_d   = cfg_cpol;
          end
        end
      end
      ST_GAP:  if (tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (latch) begin
      cs_idx_d = cmd_cs;
      tx_d     = cmd_data;
      cpol_d   = cfg_cpol;
      cpha_d   = cfg_cpha;
      lsb_d    = cfg_lsb_first;
      div_d    = cfg_div;
      last_d   = cmd_last;
    end

    if (start) begin
      state_d = ST_SETUP;
      cs_n_d  = cs_decode(cs_idx_d);
      sck_d   = cpol_d;
      edge_d  = '0;
      rx_d    = '0;
      if (!cpha_d) begin
        mosi_d = first_bit(tx_d, lsb_d);
        tx_d   = shift_out(tx_d, lsb_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cs_n_q      <= '1;
      cs_idx_q    <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      edge_q      <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      div_q       <= '0;
      last_q      <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_n_q      <= cs_n_d;
      cs_idx_q    <= cs_idx_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      edge_q      <= edge_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      div_q       <= div_d;
      last_q      <= last_d;
      pend_q      <= pend_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign cs_n      = cs_n_q;

endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
- Parametrised, runtime-configurable SPI master.
- Successor to the fixed SPI back-end of the UART-to-SPI bridge. Adds:
  - generic word width and chip-select count;
  - CPOL/CPHA modes 0-3;
  - MSB-first or LSB-first bit order;
  - a programmable clock divider;
  - multi-word transfers under one chip-select.
- Fed by a valid/ready command stream (UART front-end or test logic). Returns full-duplex receive words on a response strobe.

Parameters:
- DATA_W, 8: bits per SPI word, 4..32.
- NUM_CS, 4: number of active-low chip selects.
- CS_W, 2: width of the chip-select index, clog2(NUM_CS), minimum 1.
- DIV_W, 8: width of the clock-divider configuration.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- cfg_div  in  DIV_W  half SCK period H = cfg_div+1 clk cycles.
- cfg_cpol  in  1  SCK idle level.
- cfg_cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- cfg_lsb_first  in  1  1 = LSB shifted first.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE and CS_HELD, and only when rstn is high.
- cmd_data  in  DATA_W  word to transmit.
- cmd_cs  in  CS_W  target chip select.
- cmd_last  in  1  1 = deassert CS after this word.
- rsp_valid  out  1  one-cycle pulse; no backpressure.
- rsp_data  out  DATA_W  received word; held until the next pulse.
- busy  out  1  high in any state except IDLE.
- sck  out  1  SPI clock.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- cs_n  out  NUM_CS  one-hot-low chip selects.

Behaviour:
- Reset (async assert, sync release) drives:
  - sck=0, mosi=0, cs_n all 1;
  - rsp_valid=0, rsp_data=0, busy=0, cmd_ready=0 while rstn is low;
  - state IDLE.
- Reset asserted mid-transfer aborts it immediately. No rsp_valid is issued.
- Accept point: a command is accepted on the cycle where cmd_valid && cmd_ready. cfg_* are latched at accept; later cfg changes have no effect on the word in flight.
- States: IDLE, SETUP, SHIFT, HOLD, CS_HELD, GAP.
- IDLE: on accept go to SETUP.
  - cs_n[cmd_cs] goes low on the next cycle.
  - sck = latched cpol.
  - If CPHA=0, mosi presents the first bit.
- SETUP: lasts H cycles, then SHIFT.
- SHIFT: lasts 2*DATA_W*H cycles; one SCK edge every H cycles, 2*DATA_W edges in total.
  - CPHA=0: sample miso on each leading edge; update mosi on each trailing edge, except the final one.
  - CPHA=1: update mosi on each leading edge; sample miso on each trailing edge.
  - Bit order follows latched lsb_first, for both mosi and the receive shift register.
- HOLD: lasts H cycles with sck at idle level.
  - On exit: rsp_valid=1 for one cycle and rsp_data is updated.
  - Latency: rsp_valid occurs at cycle T+1+(2*DATA_W+2)*H, where T is the accept cycle.
  - Next state: cmd_last=1 → GAP; cmd_last=0 → CS_HELD.
- GAP: all cs_n high for H cycles, then IDLE.
- CS_HELD: cs_n stays low and cmd_ready=1.
  - New command with the same cs_index and the same cpol → SETUP directly, with CS kept low.
  - Different cs or different cpol → GAP first (CS high for H cycles), then the command starts from IDLE.
  - The command is consumed at the CS_HELD accept.
- cfg_div=0 gives H=1, i.e. SCK = clk/2.
- cmd_cs >= NUM_CS: the word is shifted with no cs_n asserted, and rsp_valid is still produced.
- miso is sampled directly on the internal edge tick. External synchronisation is the integrator's responsibility.
- Never more than one cs_n low at a time.

Decomposition:
- Package spi_pkg: state enum; SPI mode constants (MODE0..MODE3 as {cpol,cpha}).
- Sub-module spi_clk_tick: divider counter that emits a one-cycle tick every H cycles while enabled. It reloads on enable rise.
- The FSM, shift registers and CS logic stay in spi_master_cfg.

Test Plan (all scenarios use DATA_W=8, NUM_CS=4):
- Mode 0, cfg_div=1, miso looped back to mosi, cmd_data=0xA5, cs=2, last=1:
  - cs_n=4'b1011 during the transfer;
  - 8 rising sck edges;
  - rsp_data=0xA5 with rsp_valid exactly 37 cycles after accept;
  - cs_n=4'hF thereafter.
- Mode 3, cfg_div=0, miso tied 1, cmd_data=0x3C:
  - sck idles high before and after;
  - mosi is sampled MSB-first as 0,0,1,1,1,1,0,0;
  - rsp_data=0xFF.
- LSB-first, mode 1, cmd_data=0x01, miso fed with pattern 1,0,0,0,0,0,0,0:
  - first mosi bit is 1;
  - rsp_data=0x01.
- Two words to cs=0, first with last=0, second with last=1:
  - cs_n[0] stays low continuously across both words;
  - two rsp_valid pulses.
  - Repeat with the second word to cs=1: all cs_n are high for ≥H cycles between the words.
- Reset pulled low in the middle of SHIFT:
  - cs_n=4'hF, sck=0, busy=0 immediately;
  - no rsp_valid;
  - after release, a new 0x5A transfer completes correctly.
- cfg_div changed from 1 to 7 mid-transfer: the current word keeps H=2; the next word uses H=8.
